// File: rtl/cpu_sequencer.sv
// Instruction-cycle sequencer and program counter for the 12-bit processor.
// Walks fetch, decode, optional indirect and execute phases under a simple
// request/acknowledge memory handshake and generates the IR/ACC load strobes.
module cpu_sequencer #(
    parameter int unsigned          ADDR_WIDTH = 12,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  run_i,
    input  logic                  mem_ack_i,
    input  logic [ADDR_WIDTH-1:0] mem_rdata_i,
    input  logic [2:0]            ir_op_i,
    input  logic                  ir_ind_i,
    input  logic [ADDR_WIDTH-1:0] ir_addr_i,
    input  logic                  acc_zero_i,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_rd_o,
    output logic                  mem_wr_o,
    output logic                  ir_load_o,
    output logic                  acc_load_o,
    output logic [2:0]            state_o,
    output logic                  halted_o
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StIndir  = 3'd3,
        StExec   = 3'd4,
        StHalt   = 3'd5
    } state_e;

    localparam logic [2:0] OpLd  = 3'd0;
    localparam logic [2:0] OpSt  = 3'd1;
    localparam logic [2:0] OpAdd = 3'd2;
    localparam logic [2:0] OpNor = 3'd3;
    localparam logic [2:0] OpJmp = 3'd4;
    localparam logic [2:0] OpJz  = 3'd5;
    localparam logic [2:0] OpNop = 3'd6;
    localparam logic [2:0] OpHlt = 3'd7;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] ea_q, ea_d;

    // State, program counter and effective-address registers; reset wins over all.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            ea_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ea_q    <= ea_d;
        end
    end

    // Next-state decode plus Moore requests and ack-qualified load strobes.
    always_comb begin
        logic done;
        state_d    = state_q;
        pc_d       = pc_q;
        ea_d       = ea_q;
        mem_addr_o = '0;
        mem_rd_o   = 1'b0;
        mem_wr_o   = 1'b0;
        ir_load_o  = 1'b0;
        acc_load_o = 1'b0;
        halted_o   = 1'b0;
        done       = 1'b0;

        case (state_q)
            StIdle: begin
                if (run_i) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                mem_rd_o   = 1'b1;
                mem_addr_o = pc_q;
                if (mem_ack_i) begin
                    ir_load_o = 1'b1;
                    pc_d      = pc_q + 1'b1;
                    state_d   = StDecode;
                end
            end
            StDecode: begin
                if (ir_op_i == OpHlt) begin
                    state_d = StHalt;
                end else if (ir_op_i == OpNop) begin
                    state_d = run_i ? StFetch : StIdle;
                end else begin
                    ea_d    = ir_addr_i;
                    state_d = ir_ind_i ? StIndir : StExec;
                end
            end
            StIndir: begin
                mem_rd_o   = 1'b1;
                mem_addr_o = ea_q;
                if (mem_ack_i) begin
                    ea_d    = mem_rdata_i;
                    state_d = StExec;
                end
            end
            StExec: begin
                unique case (ir_op_i)
                    OpLd, OpAdd, OpNor: begin
                        mem_rd_o   = 1'b1;
                        mem_addr_o = ea_q;
                        acc_load_o = mem_ack_i;
                        done       = mem_ack_i;
                    end
                    OpSt: begin
                        mem_wr_o   = 1'b1;
                        mem_addr_o = ea_q;
                        done       = mem_ack_i;
                    end
                    OpJmp: begin
                        pc_d = ea_q;
                        done = 1'b1;
                    end
                    OpJz: begin
                        if (acc_zero_i) begin
                            pc_d = ea_q;
                        end
                        done = 1'b1;
                    end
                    // NOP/HLT never reach EXEC; retire without side effects if IR changed.
                    OpNop, OpHlt: begin
                        done = 1'b1;
                    end
                endcase
                if (done) begin
                    state_d = run_i ? StFetch : StIdle;
                end
            end
            StHalt: begin
                halted_o = 1'b1;
                if (!run_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign pc_o    = pc_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed scenarios followed by random
// instructions, checked against an instruction-level model of requests, pc and timing.
module tb_cpu_sequencer;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          run;
    logic          mem_ack;
    logic [AW-1:0] mem_rdata;
    logic [2:0]    ir_op;
    logic          ir_ind;
    logic [AW-1:0] ir_addr;
    logic          acc_zero;
    logic [AW-1:0] pc;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_wr;
    logic          ir_load;
    logic          acc_load;
    logic [2:0]    state;
    logic          halted;

    always #5 clk = ~clk;

    cpu_sequencer #(
        .ADDR_WIDTH(AW),
        .RESET_PC  (12'h000)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .run_i      (run),
        .mem_ack_i  (mem_ack),
        .mem_rdata_i(mem_rdata),
        .ir_op_i    (ir_op),
        .ir_ind_i   (ir_ind),
        .ir_addr_i  (ir_addr),
        .acc_zero_i (acc_zero),
        .pc_o       (pc),
        .mem_addr_o (mem_addr),
        .mem_rd_o   (mem_rd),
        .mem_wr_o   (mem_wr),
        .ir_load_o  (ir_load),
        .acc_load_o (acc_load),
        .state_o    (state),
        .halted_o   (halted)
    );

    // One expected memory transaction: kind, address, strobe on ack, read data, wait cycles.
    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        int            strobe; // 0 none, 1 ir_load, 2 acc_load
        logic [AW-1:0] data;
        int            waits;
    } req_t;

    req_t          exp_q[$];
    int            total = 0;
    int            bad = 0;
    logic [AW-1:0] pc_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leave IDLE: first read of pc must be visible one cycle after run is sampled.
    task automatic start();
        run = 1'b1;
        tick();
        chk("start_state", state, 3'd1);
        chk("start_rd", mem_rd, 1'b1);
        chk("start_addr", mem_addr, pc_m);
    endtask

    // Hold run in HALT for some cycles, drop it, then restart at the post-HLT pc.
    task automatic halt_exit(input int hold);
        for (int i = 0; i < hold; i++) begin
            run = 1'b1;
            tick();
            chk("halt_stay", state, 3'd5);
            chk("halt_flag", halted, 1'b1);
        end
        run = 1'b0;
        tick();
        chk("halt_exit_state", state, 3'd0);
        chk("halt_exit_flag", halted, 1'b0);
        start();
    endtask

    // Execute one instruction from the FETCH state and check every cycle of it.
    task automatic do_instr(input logic [2:0] op, input logic ind, input logic [AW-1:0] addr,
                            input logic [AW-1:0] ptr, input logic accz, input int w0,
                            input int w1, input int w2, input logic drop_run);
        logic [AW-1:0] ea;
        logic [AW-1:0] pc_inc;
        logic [AW-1:0] pc_next;
        int            ncyc;
        int            wcnt;
        int            strobe;
        logic          popped;
        req_t          r;
        logic          uses_ea;

        uses_ea = (op != 3'd6) && (op != 3'd7);
        ea      = ind ? ptr : addr;
        pc_inc  = pc_m + 12'd1;
        exp_q.delete();

        r.wr = 1'b0; r.addr = pc_m; r.strobe = 1; r.data = AW'($urandom); r.waits = w0;
        exp_q.push_back(r);
        ncyc = 2 + w0;
        if (uses_ea) begin
            ncyc += 1;
            if (ind) begin
                r.wr = 1'b0; r.addr = addr; r.strobe = 0; r.data = ptr; r.waits = w1;
                exp_q.push_back(r);
                ncyc += 1 + w1;
            end
            if (op == 3'd0 || op == 3'd2 || op == 3'd3 || op == 3'd1) begin
                r.wr     = (op == 3'd1);
                r.addr   = ea;
                r.strobe = (op == 3'd1) ? 0 : 2;
                r.data   = AW'($urandom);
                r.waits  = ind ? w2 : w1;
                exp_q.push_back(r);
                ncyc += r.waits;
            end
        end

        pc_next = pc_inc;
        if (op == 3'd4 || (op == 3'd5 && accz)) pc_next = ea;

        acc_zero = accz;
        wcnt     = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (drop_run && c == 1) run = 1'b0;
            strobe = 0;
            popped = 1'b0;
            mem_ack = 1'b0;
            if (mem_rd || mem_wr) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_req", 1, 0);
                end else begin
                    chk("req_kind", mem_wr, exp_q[0].wr);
                    chk("req_addr", mem_addr, exp_q[0].addr);
                    if (wcnt < exp_q[0].waits) begin
                        wcnt++;
                    end else begin
                        mem_ack   = 1'b1;
                        mem_rdata = exp_q[0].data;
                        strobe    = exp_q[0].strobe;
                        popped    = 1'b1;
                    end
                end
            end else begin
                // Stray acks outside request states must be ignored.
                mem_ack   = 1'($urandom_range(0, 1));
                mem_rdata = AW'($urandom);
            end
            #1;
            chk("rd_wr_excl", mem_rd & mem_wr, 1'b0);
            chk("ir_load", ir_load, strobe == 1);
            chk("acc_load", acc_load, strobe == 2);
            if (popped) begin
                void'(exp_q.pop_front());
                wcnt = 0;
            end
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (strobe == 1) begin
                ir_op   = op;
                ir_ind  = ind;
                ir_addr = addr;
                chk("pc_after_fetch", pc, pc_inc);
            end
        end
        chk("req_all_done", exp_q.size(), 0);
        if (op == 3'd7) chk("end_state", state, 3'd5);
        else chk("end_state", state, drop_run ? 3'd0 : 3'd1);
        chk("end_halted", halted, op == 3'd7);
        chk("end_pc", pc, pc_next);
        pc_m = pc_next;
    endtask

    initial begin
        logic [2:0] rop;
        logic       rdrop;

        rst_n = 1'b0; run = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        ir_op = 3'd6; ir_ind = 1'b0; ir_addr = '0; acc_zero = 1'b0;
        tick();
        tick();
        chk("rst_state", state, 3'd0);
        chk("rst_pc", pc, 12'h000);
        chk("rst_rd", mem_rd, 1'b0);
        chk("rst_wr", mem_wr, 1'b0);
        chk("rst_addr", mem_addr, 12'h000);
        chk("rst_ir_load", ir_load, 1'b0);
        chk("rst_acc_load", acc_load, 1'b0);
        chk("rst_halted", halted, 1'b0);
        rst_n = 1'b1;
        pc_m  = 12'h000;

        // NOP at 0x000, zero-wait.
        start();
        do_instr(3'd6, 1'b0, 12'h000, 12'h000, 1'b0, 0, 0, 0, 1'b0);
        // LD direct from 0x123 with a 2-cycle wait in EXEC (5 cycles total).
        do_instr(3'd0, 1'b0, 12'h123, 12'h000, 1'b0, 0, 2, 0, 1'b0);
        // ST indirect through 0x010 holding 0x456.
        do_instr(3'd1, 1'b1, 12'h010, 12'h456, 1'b0, 1, 0, 1, 1'b0);
        // JZ not taken, then taken.
        do_instr(3'd5, 1'b0, 12'h200, 12'h000, 1'b0, 0, 0, 0, 1'b0);
        do_instr(3'd5, 1'b0, 12'h200, 12'h000, 1'b1, 0, 0, 0, 1'b0);
        // Jump to 0xFFF, then JMP fetched at 0xFFF wraps pc before loading ea.
        do_instr(3'd4, 1'b0, 12'hFFF, 12'h000, 1'b0, 0, 0, 0, 1'b0);
        do_instr(3'd4, 1'b0, 12'h055, 12'h000, 1'b0, 2, 0, 0, 1'b0);
        // HLT with run held, then exit and resume.
        do_instr(3'd7, 1'b0, 12'h000, 12'h000, 1'b0, 0, 0, 0, 1'b0);
        halt_exit(3);
        // run dropped mid-instruction: ADD still completes, then IDLE.
        do_instr(3'd2, 1'b1, 12'h300, 12'h301, 1'b0, 1, 1, 1, 1'b1);
        start();

        // Reset during a FETCH wait with a simultaneous ack.
        tick();
        rst_n   = 1'b0;
        mem_ack = 1'b1;
        tick();
        rst_n   = 1'b1;
        mem_ack = 1'b0;
        chk("midrst_state", state, 3'd0);
        chk("midrst_pc", pc, 12'h000);
        chk("midrst_rd", mem_rd, 1'b0);
        chk("midrst_ir_load", ir_load, 1'b0);
        pc_m = 12'h000;
        start();

        for (int i = 0; i < 150; i++) begin
            rop   = 3'($urandom_range(0, 7));
            rdrop = (rop != 3'd7) && ($urandom_range(0, 7) == 0);
            do_instr(rop, 1'($urandom), AW'($urandom), AW'($urandom), 1'($urandom),
                     $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), rdrop);
            if (rop == 3'd7) halt_exit($urandom_range(0, 3));
            else if (rdrop) start();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Instruction-cycle sequencer and program counter for the 12-bit processor. It drives memory read/write requests and the load strobes that clock the flip-flop register banks (IR, ACC). It decides when each register captures its D inputs, so it sits directly upstream of the storage flip-flops. It walks fetch, decode, optional indirect and execute phases under a simple memory request/acknowledge handshake.

## Interface
- ADDR_WIDTH, 12, width of PC, addresses and memory data.
- RESET_PC, 0, PC value loaded on reset.

- clk  in  1  rising-edge clock for all state.
- rst_n  in  1  synchronous active-low reset.
- run  in  1  level; 1 = execute instructions, 0 = stop at next instruction boundary.
- mem_ack  in  1  memory completes the current request in this cycle.
- mem_rdata  in  ADDR_WIDTH  read data, valid when mem_ack=1.
- ir_op  in  3  opcode from IR: 0 LD, 1 ST, 2 ADD, 3 NOR, 4 JMP, 5 JZ, 6 NOP, 7 HLT.
- ir_ind  in  1  indirect-address bit from IR.
- ir_addr  in  ADDR_WIDTH  address field from IR.
- acc_zero  in  1  ACC == 0.
- pc  out  ADDR_WIDTH  program counter.
- mem_addr  out  ADDR_WIDTH  request address.
- mem_rd  out  1  read request.
- mem_wr  out  1  write request (data from ACC, external).
- ir_load  out  1  IR capture strobe.
- acc_load  out  1  ACC capture strobe (ALU result of ir_op on mem_rdata).
- state  out  3  current state encoding.
- halted  out  1  1 while in HALT.

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, INDIR=3, EXEC=4, HALT=5. Codes 6/7 are illegal and go to IDLE on the next edge.
- Reset (rst_n=0 at an edge): state=IDLE, pc=RESET_PC, ea=0. All outputs 0 except pc. Reset wins over every other event, including a pending mem_ack.
- IDLE: moves to FETCH when run=1.
- FETCH: mem_rd=1, mem_addr=pc. On mem_ack: ir_load=1 in that cycle, pc<=pc+1 (modulo 2^ADDR_WIDTH, so 0xFFF wraps to 0x000), next state DECODE.
- DECODE, no memory access:
  - HLT goes to HALT.
  - NOP goes to FETCH if run=1, else IDLE.
  - Otherwise ea<=ir_addr. Next state is INDIR if ir_ind=1, else EXEC.
- INDIR: mem_rd=1, mem_addr=ea. On mem_ack: ea<=mem_rdata, next state EXEC.
- EXEC:
  - LD/ADD/NOR: mem_rd=1, mem_addr=ea. On mem_ack, acc_load=1 in that cycle.
  - ST: mem_wr=1, mem_addr=ea; completes on mem_ack.
  - JMP: pc<=ea; completes in one cycle, no memory access.
  - JZ: pc<=ea only if acc_zero=1; completes in one cycle.
  - On completion, next state is FETCH if run=1, else IDLE.
- HALT: halted=1. Leaves to IDLE only once run=0, so a restart needs a new run assertion.
- Requests are Moore outputs (from state/ea/pc) and stay stable until acked. ir_load and acc_load are combinational: the state decode ANDed with mem_ack.
- mem_ack in IDLE, DECODE, HALT, or EXEC for JMP/JZ is ignored.
- mem_rd and mem_wr are never both 1.
- run=0 mid-instruction does not abort it. The instruction completes, then the sequencer goes to IDLE.

## Timing
- Zero-wait memory (mem_ack in the first request cycle):
  - LD/ADD/NOR/ST: 3 cycles (FETCH, DECODE, EXEC).
  - JMP/JZ: 3 cycles.
  - NOP/HLT: 2 cycles.
  - Indirect adds 1 cycle.
- Each cycle in a request state without mem_ack adds one wait cycle.
- pc changes on the edge that ends FETCH (increment) or a JMP/taken-JZ EXEC (load) only.
- IDLE→FETCH: first mem_rd appears 1 cycle after run rises at the sampling edge.
- Reset mid-request: mem_rd/mem_wr are 0 from the cycle following the reset edge.

## Test plan
- Reset, then run=1 with zero-wait memory and NOP at 0x000 → mem_rd with mem_addr=0x000 on cycle 1, pc=0x001 after the ack, state FETCH again at cycle 3.
- LD from 0x123 (direct), mem_ack delayed 2 cycles in EXEC → acc_load single-cycle pulse coincident with the ack, instruction takes 5 cycles total.
- ST indirect via ir_addr=0x010, mem_rdata=0x456 in INDIR → EXEC shows mem_wr=1, mem_addr=0x456, mem_rd=0.
- JZ to 0x200 with acc_zero=0 then acc_zero=1 → pc increments normally, then pc=0x200. JMP from pc=0xFFF fetch → pc wraps to 0x000 before EXEC loads ea.
- HLT with run held 1 → halted=1 and stays. run=0 → IDLE next edge. run=1 → fetch resumes at the post-HLT pc.
- rst_n=0 during a FETCH wait with a simultaneous mem_ack → no ir_load effect on state, pc=RESET_PC, state=IDLE, mem_rd=0 next cycle.
